// File: rtl/alu_result_tx_ctrl.sv
// ALU result consumer: buffers 2*DATA_WIDTH-bit results in a small FIFO and
// serialises each one, LS byte first, into the UART TX parallel-load handshake.
module alu_result_tx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BUF_DEPTH      = 2,
  parameter bit          ALWAYS_SEND_MS = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    RES_BUSY,
  output logic                    DROP_ERR
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoadLs,
    StAckLs,
    StDoneLs,
    StLoadMs,
    StAckMs,
    StDoneMs
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [2*DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_tx_vld;
  logic                    r_drop;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_load;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0]   w_head_ls;
  logic [DATA_WIDTH-1:0]   w_head_ms;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_ls = w_head[DATA_WIDTH-1:0];
  assign w_head_ms = w_head[2*DATA_WIDTH-1:DATA_WIDTH];

  // A pop on the same edge frees the slot, so a push while full is still taken;
  // when full, wr_ptr == rd_ptr, so the new entry lands in the slot being popped.
  assign w_push = ALU_OUT_VLD & (~w_full | w_pop);
  assign w_drop = ALU_OUT_VLD & w_full & ~w_pop;

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= ALU_OUT;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Serialiser state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  // Next state, byte load requests and head pop.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty && !TX_BUSY) begin
          w_load      = 1'b1;
          w_load_data = w_head_ls;
          w_state_nxt = StLoadLs;
        end
      end
      StLoadLs: w_state_nxt = StAckLs;
      StAckLs:  if (TX_BUSY) w_state_nxt = StDoneLs;
      StDoneLs: begin
        if (!TX_BUSY) begin
          if (!ALWAYS_SEND_MS && (w_head_ms == '0)) begin
            w_pop       = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_load      = 1'b1;
            w_load_data = w_head_ms;
            w_state_nxt = StLoadMs;
          end
        end
      end
      StLoadMs: w_state_nxt = StAckMs;
      StAckMs:  if (TX_BUSY) w_state_nxt = StDoneMs;
      StDoneMs: begin
        if (!TX_BUSY) begin
          w_pop       = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Registered TX load strobe/data and overflow pulse; data holds between loads.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_tx_vld <= w_load;
      r_drop   <= w_drop;
      if (w_load) r_tx_data <= w_load_data;
    end
  end

  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign RES_BUSY  = w_full;
  assign DROP_ERR  = r_drop;

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Bench for alu_result_tx_ctrl: instance 1 always sends the MS byte, instance 0
// skips a zero MS byte. Expected bytes go into a queue as stimulus is driven and
// are compared against the strobes logged by a negedge monitor.
module tb_alu_result_tx_ctrl;
  localparam int unsigned DW = 8;
  localparam int BUSY_LEN = 10;
  localparam int WAIT_MAX = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*DW-1:0] alu_out [2];
  logic          alu_vld  [2];
  logic          tx_busy  [2];
  logic [DW-1:0] tx_data  [2];
  logic          tx_vld   [2];
  logic          res_busy [2];
  logic          drop_err [2];
  bit            tx_auto  [2];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] obs1_q [$];
  logic [DW-1:0] obs0_q [$];
  int            obs1_cyc [$];

  alu_result_tx_ctrl #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .ALWAYS_SEND_MS(1'b1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .ALU_OUT(alu_out[1]), .ALU_OUT_VLD(alu_vld[1]),
    .TX_BUSY(tx_busy[1]), .TX_P_DATA(tx_data[1]), .TX_D_VLD(tx_vld[1]),
    .RES_BUSY(res_busy[1]), .DROP_ERR(drop_err[1])
  );

  alu_result_tx_ctrl #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .ALWAYS_SEND_MS(1'b0)) u_dut0 (
    .CLK(clk), .RST(rst_n), .ALU_OUT(alu_out[0]), .ALU_OUT_VLD(alu_vld[0]),
    .TX_BUSY(tx_busy[0]), .TX_P_DATA(tx_data[0]), .TX_D_VLD(tx_vld[0]),
    .RES_BUSY(res_busy[0]), .DROP_ERR(drop_err[0])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: busy from the cycle after a strobe, for BUSY_LEN cycles.
  task automatic tx_model(input int g);
    int dly;
    int hold;
    dly = 0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (tx_auto[g]) begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) tx_busy[g] = 1'b0;
        end else if (dly != 0) begin
          dly = 0;
          tx_busy[g] = 1'b1;
          hold = BUSY_LEN;
        end
        if (tx_vld[g] === 1'b1) dly = 1;
      end else begin
        dly = 0;
        hold = 0;
      end
    end
  endtask

  initial tx_model(0);
  initial tx_model(1);

  // Strobe monitor.
  initial forever begin
    @(negedge clk);
    if (tx_vld[1] === 1'b1) begin
      obs1_q.push_back(tx_data[1]);
      obs1_cyc.push_back(cyc);
    end
    if (tx_vld[0] === 1'b1) obs0_q.push_back(tx_data[0]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [2*DW-1:0] v);
    alu_out[g] = v;
    alu_vld[g] = 1'b1;
    step(1);
    alu_vld[g] = 1'b0;
  endtask

  task automatic settle(input int g, input int n);
    for (int k = 0; k < WAIT_MAX; k++) begin
      if ((g == 1 ? obs1_q.size() : obs0_q.size()) >= n) break;
      step(1);
    end
    step(30);
  endtask

  task automatic wait_vld1(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (tx_vld[1] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    for (int g = 0; g < 2; g++) begin
      n_cmp += 4;
      if (tx_vld[g] !== 1'b0) begin
        n_err++; $display("FAIL reset_tx_vld[%0d]: got %b want 0", g, tx_vld[g]);
      end
      if (tx_data[g] !== 8'h00) begin
        n_err++; $display("FAIL reset_tx_data[%0d]: got %h want 00", g, tx_data[g]);
      end
      if (res_busy[g] !== 1'b0) begin
        n_err++; $display("FAIL reset_res_busy[%0d]: got %b want 0", g, res_busy[g]);
      end
      if (drop_err[g] !== 1'b0) begin
        n_err++; $display("FAIL reset_drop_err[%0d]: got %b want 0", g, drop_err[g]);
      end
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic;
    logic [DW-1:0] e, o;
    int n0, c;
    tx_auto[1] = 1'b1;
    n0 = cyc;
    push(1, 16'hA55A);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    settle(1, 2);
    c = (obs1_cyc.size() > 0) ? obs1_cyc[0] : -1;
    n_cmp++;
    if (c !== n0 + 2) begin
      n_err++; $display("FAIL basic_ls_latency: got cycle %0d want %0d", c, n0 + 2);
    end
    c = (obs1_cyc.size() > 1) ? obs1_cyc[1] : -1;
    n_cmp++;
    if (c !== n0 + 14) begin
      n_err++; $display("FAIL basic_ms_timing: got cycle %0d want %0d", c, n0 + 14);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1_q.size() == 0) begin
        n_err++; $display("FAIL basic_byte: got none want %h", e);
      end else begin
        o = obs1_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL basic_byte: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (obs1_q.size() != 0) begin
      n_err++; $display("FAIL basic_extra: got %0d extra strobes want 0", obs1_q.size());
      obs1_q.delete();
    end
    obs1_cyc.delete();
  endtask

  task automatic test_skip_ms;
    logic [DW-1:0] e, o;
    tx_auto[0] = 1'b1;
    push(0, 16'h0033);
    push(0, 16'h0100);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    settle(0, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs0_q.size() == 0) begin
        n_err++; $display("FAIL skip_ms_byte: got none want %h", e);
      end else begin
        o = obs0_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL skip_ms_byte: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (obs0_q.size() != 0) begin
      n_err++; $display("FAIL skip_ms_extra: got %0d extra strobes want 0", obs0_q.size());
      obs0_q.delete();
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] e, o;
    tx_auto[1] = 1'b0;
    tx_busy[1] = 1'b1;
    step(1);
    push(1, 16'h1111);
    push(1, 16'h2222);
    n_cmp += 2;
    if (res_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL ovf_res_busy: got %b want 1", res_busy[1]);
    end
    if (drop_err[1] !== 1'b0) begin
      n_err++; $display("FAIL ovf_no_early_drop: got %b want 0", drop_err[1]);
    end
    push(1, 16'h3333);
    n_cmp++;
    if (drop_err[1] !== 1'b1) begin
      n_err++; $display("FAIL ovf_drop_pulse: got %b want 1", drop_err[1]);
    end
    step(1);
    n_cmp++;
    if (drop_err[1] !== 1'b0) begin
      n_err++; $display("FAIL ovf_drop_one_cycle: got %b want 0", drop_err[1]);
    end
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    tx_busy[1] = 1'b0;
    tx_auto[1] = 1'b1;
    settle(1, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1_q.size() == 0) begin
        n_err++; $display("FAIL ovf_byte: got none want %h", e);
      end else begin
        o = obs1_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL ovf_byte: got %h want %h", o, e); end
      end
    end
    n_cmp += 2;
    if (obs1_q.size() != 0) begin
      n_err++; $display("FAIL ovf_extra: got %0d extra strobes want 0", obs1_q.size());
      obs1_q.delete();
    end
    if (res_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL ovf_drained: got res_busy %b want 0", res_busy[1]);
    end
    obs1_cyc.delete();
  endtask

  task automatic test_full_push_pop;
    logic [DW-1:0] e, o;
    bit ok;
    tx_auto[1] = 1'b0;
    tx_busy[1] = 1'b0;
    push(1, 16'h0201);
    push(1, 16'h0403);
    wait_vld1(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL fpp_ls_strobe: got none want strobe"); end
    tx_busy[1] = 1'b1;
    step(2);
    tx_busy[1] = 1'b0;
    wait_vld1(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL fpp_ms_strobe: got none want strobe"); end
    tx_busy[1] = 1'b1;
    step(2);
    // Now in DONE_MS with both slots occupied; drop busy and push together.
    n_cmp++;
    if (res_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL fpp_full_before: got %b want 1", res_busy[1]);
    end
    tx_busy[1] = 1'b0;
    push(1, 16'h0605);
    n_cmp += 2;
    if (drop_err[1] !== 1'b0) begin
      n_err++; $display("FAIL fpp_no_drop: got %b want 0", drop_err[1]);
    end
    if (res_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL fpp_count_kept: got res_busy %b want 1", res_busy[1]);
    end
    tx_auto[1] = 1'b1;
    for (int i = 1; i <= 6; i++) exp_q.push_back(DW'(i));
    settle(1, 6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1_q.size() == 0) begin
        n_err++; $display("FAIL fpp_byte: got none want %h", e);
      end else begin
        o = obs1_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL fpp_byte: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (obs1_q.size() != 0) begin
      n_err++; $display("FAIL fpp_extra: got %0d extra strobes want 0", obs1_q.size());
      obs1_q.delete();
    end
    obs1_cyc.delete();
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] e, o;
    bit ok;
    tx_auto[1] = 1'b0;
    tx_busy[1] = 1'b0;
    push(1, 16'h5678);
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h56);
    wait_vld1(ok);
    tx_busy[1] = 1'b1;
    step(2);
    tx_busy[1] = 1'b0;
    wait_vld1(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid_ms_strobe: got none want strobe"); end
    push(1, 16'h9999);
    // In ACK_MS (busy stays low) with a second entry queued.
    n_cmp++;
    if (res_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL rstmid_full_before: got %b want 1", res_busy[1]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (tx_vld[1] !== 1'b0) begin
      n_err++; $display("FAIL rstmid_tx_vld: got %b want 0", tx_vld[1]);
    end
    if (tx_data[1] !== 8'h00) begin
      n_err++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data[1]);
    end
    if (res_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL rstmid_res_busy: got %b want 0", res_busy[1]);
    end
    if (drop_err[1] !== 1'b0) begin
      n_err++; $display("FAIL rstmid_drop_err: got %b want 0", drop_err[1]);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
    tx_auto[1] = 1'b1;
    push(1, 16'hBEEF);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    settle(1, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1_q.size() == 0) begin
        n_err++; $display("FAIL rstmid_byte: got none want %h", e);
      end else begin
        o = obs1_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL rstmid_byte: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (obs1_q.size() != 0) begin
      n_err++; $display("FAIL rstmid_extra: got %0d extra strobes want 0", obs1_q.size());
      obs1_q.delete();
    end
    obs1_cyc.delete();
  endtask

  task automatic test_busy_startup;
    logic [DW-1:0] e, o;
    bit ok;
    int f, c;
    tx_auto[1] = 1'b0;
    tx_busy[1] = 1'b1;
    step(1);
    push(1, 16'h1234);
    step(8);
    n_cmp++;
    if (obs1_q.size() != 0) begin
      n_err++; $display("FAIL busy_hold: got %0d strobes want 0", obs1_q.size());
    end
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    f = cyc;
    tx_busy[1] = 1'b0;
    tx_auto[1] = 1'b1;
    wait_vld1(ok);
    settle(1, 2);
    c = (obs1_cyc.size() > 0) ? obs1_cyc[0] : -1;
    n_cmp++;
    if (c !== f + 1) begin
      n_err++; $display("FAIL busy_release_latency: got cycle %0d want %0d", c, f + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs1_q.size() == 0) begin
        n_err++; $display("FAIL busy_byte: got none want %h", e);
      end else begin
        o = obs1_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL busy_byte: got %h want %h", o, e); end
      end
    end
    n_cmp++;
    if (obs1_q.size() != 0) begin
      n_err++; $display("FAIL busy_extra: got %0d extra strobes want 0", obs1_q.size());
      obs1_q.delete();
    end
    obs1_cyc.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      alu_out[g] = '0;
      alu_vld[g] = 1'b0;
      tx_busy[g] = 1'b0;
      tx_auto[g] = 1'b0;
    end
    test_reset();
    test_basic();
    test_skip_ms();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_busy_startup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
